// File: rtl/arp_responder.sv
// ARP responder: parses a 28-byte ARP payload stream, learns sender bindings
// into the ARP cache and answers requests for the local IP with a reply payload.
module arp_responder (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] local_ip_i,
    input  logic [47:0] local_mac_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    input  logic [7:0]  s_data_i,
    input  logic        s_last_i,
    output logic        m_valid_o,
    input  logic        m_ready_i,
    output logic [7:0]  m_data_o,
    output logic        m_last_o,
    output logic [47:0] m_dst_mac_o,
    output logic        write_valid_o,
    output logic [31:0] write_ip_o,
    output logic [47:0] write_mac_o
);

    typedef enum logic {ST_RX, ST_TX} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  hdr_q [28];
    logic [7:0]  hdr_d [28];
    logic        write_valid_q, write_valid_d;
    logic [31:0] write_ip_q, write_ip_d;
    logic [47:0] write_mac_q, write_mac_d;

    logic        beat_in;
    logic        hdr_ok;
    logic [47:0] new_sha;
    logic [31:0] new_spa;
    logic [31:0] new_tpa;
    logic [47:0] req_sha;
    logic [31:0] req_spa;
    logic [223:0] reply_vec;
    logic [223:0] tx_shift;

    assign beat_in = (state_q == ST_RX) && s_valid_i;

    always_comb begin
        hdr_d = hdr_q;
        if (beat_in && (cnt_q < 5'd28)) begin
            hdr_d[cnt_q] = s_data_i;
        end
    end

    // Decode from the next-state view so the byte arriving with s_last_i counts.
    assign new_sha = {hdr_d[8], hdr_d[9], hdr_d[10], hdr_d[11], hdr_d[12], hdr_d[13]};
    assign new_spa = {hdr_d[14], hdr_d[15], hdr_d[16], hdr_d[17]};
    assign new_tpa = {hdr_d[24], hdr_d[25], hdr_d[26], hdr_d[27]};
    assign hdr_ok  = ({hdr_d[0], hdr_d[1]} == 16'h0001) &&
                     ({hdr_d[2], hdr_d[3]} == 16'h0800) &&
                     (hdr_d[4] == 8'd6) && (hdr_d[5] == 8'd4) &&
                     (hdr_d[6] == 8'd0) &&
                     ((hdr_d[7] == 8'd1) || (hdr_d[7] == 8'd2));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        write_valid_d = 1'b0;
        write_ip_d    = write_ip_q;
        write_mac_d   = write_mac_q;
        case (state_q)
            ST_RX: begin
                if (s_valid_i) begin
                    if (cnt_q < 5'd28) begin
                        cnt_d = cnt_q + 5'd1;
                    end
                    if (s_last_i) begin
                        cnt_d = 5'd0;
                        if ((cnt_q >= 5'd27) && hdr_ok) begin
                            if (new_spa != 32'd0) begin
                                write_valid_d = 1'b1;
                                write_ip_d    = new_spa;
                                write_mac_d   = new_sha;
                            end
                            if ((hdr_d[7] == 8'd1) && (new_tpa == local_ip_i)) begin
                                state_d = ST_TX;
                            end
                        end
                    end
                end
            end
            ST_TX: begin
                if (m_ready_i) begin
                    if (cnt_q == 5'd27) begin
                        state_d = ST_RX;
                        cnt_d   = 5'd0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = ST_RX;
                cnt_d   = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RX;
            cnt_q         <= 5'd0;
            write_valid_q <= 1'b0;
            write_ip_q    <= 32'd0;
            write_mac_q   <= 48'd0;
            for (int i = 0; i < 28; i++) begin
                hdr_q[i] <= 8'h00;
            end
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            write_valid_q <= write_valid_d;
            write_ip_q    <= write_ip_d;
            write_mac_q   <= write_mac_d;
            hdr_q         <= hdr_d;
        end
    end

    // In TX the counter doubles as the reply byte index.
    assign req_sha   = {hdr_q[8], hdr_q[9], hdr_q[10], hdr_q[11], hdr_q[12], hdr_q[13]};
    assign req_spa   = {hdr_q[14], hdr_q[15], hdr_q[16], hdr_q[17]};
    assign reply_vec = {64'h0001_0800_0604_0002, local_mac_i, local_ip_i, req_sha, req_spa};
    assign tx_shift  = reply_vec << {cnt_q, 3'b000};

    assign s_ready_o     = (state_q == ST_RX);
    assign m_valid_o     = (state_q == ST_TX);
    assign m_last_o      = m_valid_o && (cnt_q == 5'd27);
    assign m_data_o      = m_valid_o ? tx_shift[223:216] : 8'h00;
    assign m_dst_mac_o   = req_sha;
    assign write_valid_o = write_valid_q;
    assign write_ip_o    = write_ip_q;
    assign write_mac_o   = write_mac_q;

endmodule

// File: tb/tb_arp_responder.sv
// Randomized scoreboard bench for arp_responder: a frame-level reference model
// queues expected cache writes and reply beats; a monitor checks DUT outputs.
module tb_arp_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] local_ip_i;
    logic [47:0] local_mac_i;
    logic        s_valid_i;
    logic        s_ready_o;
    logic [7:0]  s_data_i;
    logic        s_last_i;
    logic        m_valid_o;
    logic        m_ready_i;
    logic [7:0]  m_data_o;
    logic        m_last_o;
    logic [47:0] m_dst_mac_o;
    logic        write_valid_o;
    logic [31:0] write_ip_o;
    logic [47:0] write_mac_o;

    arp_responder dut (
        .clk(clk), .rst(rst),
        .local_ip_i(local_ip_i), .local_mac_i(local_mac_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i), .s_last_i(s_last_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o), .m_last_o(m_last_o),
        .m_dst_mac_o(m_dst_mac_o),
        .write_valid_o(write_valid_o), .write_ip_o(write_ip_o), .write_mac_o(write_mac_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        last;
        logic [47:0] dst;
    } beat_t;

    typedef struct {
        logic [31:0] ip;
        logic [47:0] mac;
        int          cyc;
    } wr_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int beats_seen = 0;
    bit rand_ready = 1'b0;
    bit gaps = 1'b0;

    beat_t      exp_beats[$];
    wr_t        exp_wr[$];
    int         exp_start[$];
    logic [7:0] frame[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        m_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor
    bit         prev_valid = 1'b0;
    bit         held = 1'b0;
    logic [7:0] held_data;
    logic       held_last;
    beat_t      mb;
    wr_t        mw;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            held       = 1'b0;
        end else begin
            if (m_valid_o) begin
                chk("s_ready_during_tx", 64'(s_ready_o), 64'd0);
                if (!prev_valid) begin
                    if (exp_start.size() == 0) chk("unexpected_reply_start", 64'(m_valid_o), 64'd0);
                    else chk("reply_start_cycle", 64'(cyc), 64'(exp_start.pop_front()));
                end
                if (held) chk("stall_hold", 64'({m_data_o, m_last_o}), 64'({held_data, held_last}));
                if (m_ready_i) begin
                    held = 1'b0;
                    if (exp_beats.size() == 0) begin
                        chk("unexpected_reply_beat", 64'(m_valid_o), 64'd0);
                    end else begin
                        mb = exp_beats.pop_front();
                        chk("reply_data", 64'(m_data_o), 64'(mb.data));
                        chk("reply_last", 64'(m_last_o), 64'(mb.last));
                        chk("reply_dst_mac", 64'(m_dst_mac_o), 64'(mb.dst));
                    end
                    beats_seen++;
                end else begin
                    held      = 1'b1;
                    held_data = m_data_o;
                    held_last = m_last_o;
                end
            end else begin
                held = 1'b0;
            end
            prev_valid = m_valid_o;
            if (write_valid_o) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", 64'(write_valid_o), 64'd0);
                end else begin
                    mw = exp_wr.pop_front();
                    chk("write_ip", 64'(write_ip_o), 64'(mw.ip));
                    chk("write_mac", 64'(write_mac_o), 64'(mw.mac));
                    chk("write_cycle", 64'(cyc), 64'(mw.cyc));
                end
            end
        end
    end

    // Reference model: acts on a whole frame; c_last is the cycle of the last beat.
    task automatic model(input int c_last);
        logic [15:0]  htype, ptype, oper;
        logic [47:0]  sha;
        logic [31:0]  spa, tpa;
        logic [223:0] v;
        beat_t        b;
        wr_t          w;
        if (frame.size() < 28) return;
        htype = {frame[0], frame[1]};
        ptype = {frame[2], frame[3]};
        oper  = {frame[6], frame[7]};
        sha   = {frame[8], frame[9], frame[10], frame[11], frame[12], frame[13]};
        spa   = {frame[14], frame[15], frame[16], frame[17]};
        tpa   = {frame[24], frame[25], frame[26], frame[27]};
        if (htype != 16'h0001 || ptype != 16'h0800 || frame[4] != 8'd6 || frame[5] != 8'd4) return;
        if (oper != 16'd1 && oper != 16'd2) return;
        if (spa != 32'd0) begin
            w.ip = spa; w.mac = sha; w.cyc = c_last + 1;
            exp_wr.push_back(w);
        end
        if (oper == 16'd1 && tpa == local_ip_i) begin
            exp_start.push_back(c_last + 1);
            v = {64'h0001_0800_0604_0002, local_mac_i, local_ip_i, sha, spa};
            for (int i = 0; i < 28; i++) begin
                b.data = v[223:216];
                b.last = (i == 27);
                b.dst  = sha;
                exp_beats.push_back(b);
                v = v << 8;
            end
        end
    endtask

    task automatic build(input logic [15:0] htype, input logic [15:0] oper, input logic [47:0] sha,
                         input logic [31:0] spa, input logic [31:0] tpa, input int total);
        logic [223:0] v;
        v = {htype, 16'h0800, 8'h06, 8'h04, oper, sha, spa, 48'h0, tpa};
        frame.delete();
        for (int i = 0; i < 28; i++) begin
            frame.push_back(v[223:216]);
            v = v << 8;
        end
        while (frame.size() < total) frame.push_back(8'($urandom));
        while (frame.size() > total) void'(frame.pop_back());
    endtask

    task automatic send(input bit chk_ready);
        bit rdy;
        int c_last;
        int n;
        c_last = 0;
        for (int i = 0; i < frame.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_valid_i = 1'b0;
                @(posedge clk);
                #1;
            end
            s_valid_i = 1'b1;
            s_data_i  = frame[i];
            s_last_i  = (i == frame.size() - 1);
            n = 0;
            forever begin
                @(negedge clk);
                rdy    = s_ready_o;
                c_last = cyc;
                if (chk_ready) chk("s_ready_padded", 64'(rdy), 64'd1);
                @(posedge clk);
                #1;
                if (rdy) break;
                n++;
                if (n > 2000) begin
                    chk("send_timeout", 64'(n), 64'd0);
                    s_valid_i = 1'b0;
                    s_last_i  = 1'b0;
                    return;
                end
            end
        end
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        model(c_last);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_beats.size() + exp_wr.size() + exp_start.size()) != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("drain_pending", 64'(exp_beats.size() + exp_wr.size() + exp_start.size()), 64'd0);
    endtask

    localparam logic [47:0] MAC_A = 48'h02_00_00_00_00_01;
    localparam logic [47:0] MAC_L = 48'h02_00_00_00_00_02;
    localparam logic [31:0] IP_A  = 32'h0A00_0001;
    localparam logic [31:0] IP_L  = 32'h0A00_0002;

    initial begin
        int base;
        int n;
        rst         = 1'b1;
        local_ip_i  = IP_L;
        local_mac_i = MAC_L;
        s_valid_i   = 1'b0;
        s_data_i    = 8'h00;
        s_last_i    = 1'b0;
        #2;
        chk("rst_s_ready", 64'(s_ready_o), 64'd1);
        chk("rst_m_valid", 64'(m_valid_o), 64'd0);
        chk("rst_m_last", 64'(m_last_o), 64'd0);
        chk("rst_write_valid", 64'(write_valid_o), 64'd0);
        chk("rst_write_ip", 64'(write_ip_o), 64'd0);
        chk("rst_write_mac", 64'(write_mac_o), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic request for the local IP
        build(16'h0001, 16'd1, MAC_A, IP_A, IP_L, 28);
        send(1'b0);
        wait_idle();

        // Request for another host, a reply frame, then a probe with SPA=0
        build(16'h0001, 16'd1, MAC_A, IP_A, 32'h0A00_0009, 28);
        send(1'b0);
        build(16'h0001, 16'd2, 48'h02_00_00_00_00_33, 32'h0A00_0033, IP_L, 28);
        send(1'b0);
        build(16'h0001, 16'd1, 48'h02_00_00_00_00_44, 32'h0, 32'h0A00_0009, 28);
        send(1'b0);
        wait_idle();

        // Short frame, bad HTYPE, then a valid request
        build(16'h0001, 16'd1, MAC_A, IP_A, IP_L, 20);
        send(1'b0);
        build(16'h0006, 16'd1, MAC_A, IP_A, IP_L, 28);
        send(1'b0);
        build(16'h0001, 16'd1, MAC_A, IP_A, IP_L, 28);
        send(1'b0);
        wait_idle();

        // Padded 46-byte request, every beat accepted at once
        build(16'h0001, 16'd1, MAC_A, IP_A, IP_L, 46);
        send(1'b1);
        wait_idle();

        // Stalled reply, with a second request issued while transmitting
        rand_ready = 1'b1;
        gaps       = 1'b1;
        build(16'h0001, 16'd1, MAC_A, IP_A, IP_L, 28);
        send(1'b0);
        build(16'h0001, 16'd1, 48'h02_00_00_00_00_55, 32'h0A00_0055, IP_L, 30);
        send(1'b0);
        wait_idle();
        rand_ready = 1'b0;
        gaps       = 1'b0;

        // Reset at reply byte 10
        base = beats_seen;
        build(16'h0001, 16'd1, MAC_A, IP_A, IP_L, 28);
        send(1'b0);
        n = 0;
        forever begin
            @(posedge clk);
            #2;
            if ((beats_seen >= base + 10) && m_valid_o) break;
            n++;
            if (n > 500) begin
                chk("reset_scenario_timeout", 64'(n), 64'd0);
                break;
            end
        end
        rst = 1'b1;
        #1;
        chk("rst_mid_reply_m_valid", 64'(m_valid_o), 64'd0);
        chk("rst_mid_reply_write", 64'(write_valid_o), 64'd0);
        chk("rst_mid_reply_write_queue", 64'(exp_wr.size()), 64'd0);
        exp_beats.delete();
        exp_start.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_s_ready", 64'(s_ready_o), 64'd1);
        chk("post_rst_m_valid", 64'(m_valid_o), 64'd0);
        @(posedge clk);
        #1;
        base = beats_seen;
        build(16'h0001, 16'd1, MAC_A, IP_A, IP_L, 28);
        send(1'b0);
        wait_idle();
        chk("post_rst_reply_len", 64'(beats_seen - base), 64'd28);

        // Randomized traffic
        rand_ready = 1'b1;
        gaps       = 1'b1;
        for (int k = 0; k < 40; k++) begin
            logic [15:0] ht, op;
            logic [47:0] sha;
            logic [31:0] spa, tpa;
            int          len, sel;
            sel = $urandom_range(0, 9);
            ht  = (sel == 0) ? 16'($urandom_range(2, 9)) : 16'h0001;
            op  = (sel == 1) ? 16'd3 : 16'($urandom_range(1, 2));
            sha = {16'($urandom), 32'($urandom)};
            spa = (sel == 2) ? 32'd0 : 32'($urandom);
            tpa = ($urandom_range(0, 1) == 1) ? IP_L : 32'($urandom);
            len = (sel == 3) ? $urandom_range(1, 27) : 28 + $urandom_range(0, 18);
            build(ht, op, sha, spa, tpa, len);
            send(1'b0);
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/arp_responder.md
Name: arp_responder

Overview:
- Consumes ARP payloads (Ethernet header already stripped) as an 8-bit stream.
- Learns sender IP->MAC bindings by driving the ARP cache write port (write_valid/write_ip/write_mac).
- Answers ARP requests addressed to the local IP with a 28-byte reply payload stream.
- Sits between the RX ethertype demux (0x0806 branch) and the TX Ethernet framer, beside arp_cache.

Parameters:
- None. Field layout is fixed: Ethernet/IPv4 ARP, 28 bytes, network byte order.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- local_ip_i  in  32  own IPv4 address, static while not idle
- local_mac_i  in  48  own MAC address, static while not idle
- s_valid_i  in  1  input beat valid
- s_ready_o  out  1  input beat accepted when s_valid_i & s_ready_o
- s_data_i  in  8  input byte
- s_last_i  in  1  final byte of frame (may include Ethernet padding)
- m_valid_o  out  1  reply beat valid
- m_ready_i  in  1  downstream ready
- m_data_o  out  8  reply byte
- m_last_o  out  1  reply byte 27
- m_dst_mac_o  out  48  destination MAC for framer (= request SHA), stable while m_valid_o
- write_valid_o  out  1  1-cycle cache write strobe
- write_ip_o  out  32  learned IP
- write_mac_o  out  48  learned MAC

Behaviour:
- States: RX (reset state), TX. s_ready_o = (state==RX); it is 1 out of reset. Reset also clears: m_valid_o=0, m_last_o=0, write_valid_o=0, byte counter=0, all field registers=0.
- RX: each accepted byte is stored by index into HTYPE[0:1], PTYPE[2:3], HLEN[4], PLEN[5], OPER[6:7], SHA[8:13], SPA[14:17], THA[18:23], TPA[24:27]. The byte counter (5 bits) saturates at 28. Bytes at index >= 28 are discarded.
- Accepted s_last_i at counter < 27 means a short frame: drop it. No write, no reply, counter returns to 0.
- Accepted s_last_i at counter >= 27 means a complete frame. The header is valid iff HTYPE=0x0001, PTYPE=0x0800, HLEN=6, PLEN=4, OPER in {1,2}.
- Learn: on a valid header with SPA != 0, write_valid_o=1 in the cycle after the last beat, for exactly 1 cycle. write_ip_o=SPA and write_mac_o=SHA, held until the next write.
- Reply: on a valid header with OPER=1 and TPA=local_ip_i, enter TX; m_valid_o=1 in the cycle after the last beat.
  - The learn write fires in that same cycle.
  - Any other completed frame keeps the block in RX with counter=0.
- TX: 28 bytes, in order:
  - 00 01 08 00 06 04 00 02
  - local_mac (6 bytes)
  - local_ip (4 bytes)
  - request SHA (6 bytes)
  - request SPA (4 bytes)
- TX handshake: a byte advances only on m_valid_o & m_ready_i. m_data_o and m_last_o hold while stalled. m_last_o=1 only on byte 27.
- After byte 27 is accepted: return to RX, m_valid_o=0, s_ready_o=1 on the next cycle.
- The input is back-pressured for the whole of TX. No overlap and no reply queue, so at most 1 reply is outstanding.
- local_ip_i/local_mac_i are sampled combinationally for the TPA compare and for TX bytes. They must not change during a frame.
- s_valid_i deasserted mid-frame: the counter holds; there is no timeout.
- Reset mid-frame or mid-reply: the partial frame or reply is abandoned. m_valid_o drops asynchronously and no write is issued.

Test Plan:
- Request (SHA=02:00:00:00:00:01, SPA=10.0.0.1, TPA=local 10.0.0.2, local_mac=02:00:00:00:00:02), no stall:
  - write_valid_o for 1 cycle with ip=0x0A000001, mac=0x020000000001.
  - 28-byte reply ...00 02, 02 00 00 00 00 02, 0A 00 00 02, 02 00 00 00 00 01, 0A 00 00 01.
  - m_last_o on byte 27; m_dst_mac_o=0x020000000001.
- Same request with TPA=10.0.0.9, then an OPER=2 reply frame:
  - 2 writes, no m_valid_o.
  - SPA=0 probe produces no write.
- 20-byte frame with s_last_i, and a frame with HTYPE=0x0006:
  - no write, no reply.
  - A following valid request is handled correctly.
- 46-byte padded request:
  - the reply is identical to the first scenario.
  - s_ready_o=1 for all 46 beats.
- Random m_ready_i (50%) during reply:
  - byte sequence unchanged, m_data_o stable across stalls.
  - s_ready_o=0 until byte 27 is accepted.
  - A request issued during TX is accepted after it.
- rst pulsed at reply byte 10:
  - m_valid_o=0 immediately, s_ready_o=1 after release.
  - The next request yields a full 28-byte reply.
